// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: funct3 codes, exception codes, FSM states, WB entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [4:0]  rd_addr;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [31:0] pc4;
    exc_e        exc;
  } wb_entry_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port: word-addressed request with byte enables, completion signalled by ready.
// Latency: variable, set by the memory; ready marks the completing cycle.
// Backpressure: requester holds req and all request fields stable until ready.
// Ports: req/we/addr/be/wdata (requester -> memory), ready/rdata (memory -> requester).
interface mem_stage_lsu_if #(
  parameter int P_DMEM_ADDR_WIDTH = 10
);
  logic                         req;
  logic                         we;
  logic [P_DMEM_ADDR_WIDTH-3:0] addr;
  logic [3:0]                   be;
  logic [31:0]                  wdata;
  logic                         ready;
  logic [31:0]                  rdata;

  modport master (output req, we, addr, be, wdata, input ready, rdata);
  modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Access checking and lane handling: illegal/misaligned detect, store byte enables and lane
// replication, load lane extraction with sign/zero extension.
// Latency: combinational. Backpressure: none.
// Ports: memread/memwrite/funct3/addr_lo/store_data/rdata in; illegal/misalign/be/wdata/load_data out.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        illegal,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  always_comb begin
    illegal = 1'b0;
    if (memread && memwrite)
      illegal = 1'b1;
    else if (memread)
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (memwrite)
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
  end

  // Size lives in funct3[1:0]; size 11 is always illegal so it needs no check here
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = (addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Loads always fetch the full word; lane selection happens on the way back
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (memwrite) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    lane = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {24'b0, lane[7:0]};
      F3_HU:   load_data = {16'b0, lane[15:0]};
      default: load_data = lane;  // LW is word aligned, so lane == rdata
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32 MEM stage with load/store unit; owns the MEM/WB register.
// Latency: 1 cycle for non-memory ops and zero-wait accesses; k-wait access completes on the edge ending the ready cycle.
// Backpressure: o_stall_m holds IF..MEM while a request is outstanding; hung accesses abort after P_TIMEOUT wait cycles.
// Ports: i_clk/i_rst_n; i_*_m MEM-stage controls and data; dmem (data-memory master port); o_stall_m; o_*_w MEM/WB register.
module mem_stage_lsu
  import mem_lsu_pkg::*;
#(
  parameter int P_DMEM_ADDR_WIDTH = 10,
  parameter int P_TIMEOUT         = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_m,
  input  logic        i_regwrite_m,
  input  logic        i_memread_m,
  input  logic        i_memwrite_m,
  input  logic [1:0]  i_resultsrc_m,
  input  logic [2:0]  i_funct3_m,
  input  logic [31:0] i_alu_result_m,
  input  logic [31:0] i_write_data_m,
  input  logic [31:0] i_pc4_m,
  input  logic [4:0]  i_rd_addr_m,
  mem_stage_lsu_if.master dmem,
  output logic        o_stall_m,
  output logic        o_valid_w,
  output logic        o_regwrite_w,
  output logic [1:0]  o_resultsrc_w,
  output logic [4:0]  o_rd_addr_w,
  output logic [31:0] o_read_data_w,
  output logic [31:0] o_alu_result_w,
  output logic [31:0] o_pc4_w,
  output logic [1:0]  o_exc_w
);

  localparam int CW = $clog2(P_TIMEOUT + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        illegal, misalign;
  logic        mem_op, legal_op;
  logic        req, abort, stall;
  logic [31:0] load_data;
  wb_entry_t   wb_q;

  lsu_align u_align (
    .memread    (i_memread_m),
    .memwrite   (i_memwrite_m),
    .funct3     (i_funct3_m),
    .addr_lo    (i_alu_result_m[1:0]),
    .store_data (i_write_data_m),
    .rdata      (dmem.rdata),
    .illegal    (illegal),
    .misalign   (misalign),
    .be         (dmem.be),
    .wdata      (dmem.wdata),
    .load_data  (load_data)
  );

  assign mem_op   = i_valid_m & (i_memread_m | i_memwrite_m);
  assign legal_op = mem_op & ~illegal & ~misalign;

  // Inputs are frozen while stalled, so the request can be derived from them in both states
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    req     = i_rst_n & legal_op;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req && !dmem.ready) begin
          state_d = WAIT;
          cnt_d   = CW'(1);  // counts the first wait cycle
        end
      end
      WAIT: begin
        if (!req || dmem.ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(P_TIMEOUT)) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall = req & ~dmem.ready & ~abort;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: bubble while stalled; exceptions keep PC+4/address for the trap path
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wb_q <= '0;
    end else if (!i_valid_m || stall) begin
      wb_q <= '0;
    end else begin
      wb_q.valid      <= 1'b1;
      wb_q.regwrite   <= i_regwrite_m;
      wb_q.resultsrc  <= i_resultsrc_m;
      wb_q.rd_addr    <= i_rd_addr_m;
      wb_q.alu_result <= i_alu_result_m;
      wb_q.pc4        <= i_pc4_m;
      wb_q.read_data  <= '0;
      wb_q.exc        <= EXC_NONE;
      if (mem_op) begin
        if (illegal) begin
          wb_q.regwrite <= 1'b0;
          wb_q.exc      <= EXC_ILLEGAL;
        end else if (misalign) begin
          wb_q.regwrite <= 1'b0;
          wb_q.exc      <= EXC_MISALIGN;
        end else if (abort) begin
          wb_q.regwrite <= 1'b0;
          wb_q.exc      <= EXC_TIMEOUT;
        end else if (i_memread_m) begin
          wb_q.read_data <= load_data;
        end
      end
    end
  end

  assign dmem.req  = req;
  assign dmem.we   = i_memwrite_m;
  assign dmem.addr = i_alu_result_m[P_DMEM_ADDR_WIDTH-1:2];
  assign o_stall_m = stall;

  assign o_valid_w      = wb_q.valid;
  assign o_regwrite_w   = wb_q.regwrite;
  assign o_resultsrc_w  = wb_q.resultsrc;
  assign o_rd_addr_w    = wb_q.rd_addr;
  assign o_read_data_w  = wb_q.read_data;
  assign o_alu_result_w = wb_q.alu_result;
  assign o_pc4_w        = wb_q.pc4;
  assign o_exc_w        = wb_q.exc;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: scripted accesses against a delay-programmable memory, WB scoreboard.
// Latency: n/a. Backpressure: memory ready driven per access with a chosen delay.
module tb_mem_stage_lsu;
  import mem_lsu_pkg::*;

  localparam int AW = 10;
  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid_m, i_regwrite_m, i_memread_m, i_memwrite_m;
  logic [1:0]  i_resultsrc_m;
  logic [2:0]  i_funct3_m;
  logic [31:0] i_alu_result_m, i_write_data_m, i_pc4_m;
  logic [4:0]  i_rd_addr_m;
  logic        o_stall_m, o_valid_w, o_regwrite_w;
  logic [1:0]  o_resultsrc_w, o_exc_w;
  logic [4:0]  o_rd_addr_w;
  logic [31:0] o_read_data_w, o_alu_result_w, o_pc4_w;

  mem_stage_lsu_if #(.P_DMEM_ADDR_WIDTH(AW)) dmem_if ();

  mem_stage_lsu #(.P_DMEM_ADDR_WIDTH(AW), .P_TIMEOUT(TO)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid_m      (i_valid_m),
    .i_regwrite_m   (i_regwrite_m),
    .i_memread_m    (i_memread_m),
    .i_memwrite_m   (i_memwrite_m),
    .i_resultsrc_m  (i_resultsrc_m),
    .i_funct3_m     (i_funct3_m),
    .i_alu_result_m (i_alu_result_m),
    .i_write_data_m (i_write_data_m),
    .i_pc4_m        (i_pc4_m),
    .i_rd_addr_m    (i_rd_addr_m),
    .dmem           (dmem_if),
    .o_stall_m      (o_stall_m),
    .o_valid_w      (o_valid_w),
    .o_regwrite_w   (o_regwrite_w),
    .o_resultsrc_w  (o_resultsrc_w),
    .o_rd_addr_w    (o_rd_addr_w),
    .o_read_data_w  (o_read_data_w),
    .o_alu_result_w (o_alu_result_w),
    .o_pc4_w        (o_pc4_w),
    .o_exc_w        (o_exc_w)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   seq   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // WB monitor: every valid entry must match the oldest expectation
  always @(negedge i_clk) begin : wb_mon
    exp_t e;
    if (o_valid_w === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_regwrite",  32'(o_regwrite_w),  32'(e.regwrite));
        chk("wb_resultsrc", 32'(o_resultsrc_w), 32'(e.resultsrc));
        chk("wb_rd",        32'(o_rd_addr_w),   32'(e.rd));
        chk("wb_read_data", o_read_data_w,      e.rdata);
        chk("wb_alu",       o_alu_result_w,     e.alu);
        chk("wb_pc4",       o_pc4_w,            e.pc4);
        chk("wb_exc",       32'(o_exc_w),       32'(e.exc));
      end
    end
  end

  task automatic idle_inputs();
    i_valid_m      = 1'b0;
    i_regwrite_m   = 1'b0;
    i_memread_m    = 1'b0;
    i_memwrite_m   = 1'b0;
    i_resultsrc_m  = 2'b00;
    i_funct3_m     = 3'b000;
    i_alu_result_m = 32'h0;
    i_write_data_m = 32'h0;
    i_pc4_m        = 32'h0;
    i_rd_addr_m    = 5'd0;
    dmem_if.ready  = 1'b0;
    dmem_if.rdata  = 32'h0;
  endtask

  // Present one op (called just after a rising edge). dly = request cycle in which ready
  // rises (0 = same cycle, -1 = never). Expected WB entry goes to the scoreboard here.
  task automatic issue(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                       input int dly, input logic [1:0] exc, input logic [31:0] exp_rd,
                       input int exp_stall, input int exp_req,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_t e;
    int   stalls = 0;
    int   reqs   = 0;
    logic done   = 1'b0;
    logic st;
    logic [3:0]  cap_be    = 4'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [31:0] cap_addr  = 32'h0;
    logic        cap_we    = 1'b0;
    seq++;
    i_valid_m      = 1'b1;
    i_memread_m    = mr;
    i_memwrite_m   = mw;
    i_regwrite_m   = rw;
    i_funct3_m     = f3;
    i_alu_result_m = addr;
    i_write_data_m = wd;
    i_resultsrc_m  = 2'(seq);
    i_rd_addr_m    = 5'(seq + 1);
    i_pc4_m        = 32'h400 + 32'(seq * 4);
    e.regwrite  = rw && (exc == 2'b00);
    e.resultsrc = 2'(seq);
    e.rd        = 5'(seq + 1);
    e.rdata     = exp_rd;
    e.alu       = addr;
    e.pc4       = 32'h400 + 32'(seq * 4);
    e.exc       = exc;
    sb.push_back(e);
    for (int n = 0; n < 40 && !done; n++) begin
      dmem_if.ready = (n == dly);
      dmem_if.rdata = (n == dly) ? rdat : 32'hDEAD_BEEF;
      @(negedge i_clk);
      st = o_stall_m;
      if (dmem_if.req === 1'b1) begin
        if (reqs == 0) begin
          cap_be    = dmem_if.be;
          cap_wdata = dmem_if.wdata;
          cap_addr  = 32'(dmem_if.addr);
          cap_we    = dmem_if.we;
        end
        reqs++;
      end
      if (st === 1'b1) stalls++;
      @(posedge i_clk);
      #1;
      if (st !== 1'b1) done = 1'b1;
    end
    chk("op_completes", 32'(done), 32'd1);
    chk("wb_latency", 32'(o_valid_w), 32'd1);
    chk("stall_cycles", stalls, exp_stall);
    chk("req_cycles", reqs, exp_req);
    if (exp_req > 0) begin
      chk("dmem_be", 32'(cap_be), 32'(exp_be));
      chk("dmem_addr", cap_addr, 32'(addr[AW-1:2]));
      chk("dmem_we", 32'(cap_we), 32'(mw));
      if (mw) chk("dmem_wdata", cap_wdata, exp_wdata);
    end
    idle_inputs();
    @(posedge i_clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    // A legal load presented during reset must not produce a request
    i_valid_m = 1'b1; i_memread_m = 1'b1; i_funct3_m = F3_W; i_alu_result_m = 32'h100;
    @(negedge i_clk);
    chk("rst_valid_w",  32'(o_valid_w), 32'd0);
    chk("rst_regwrite", 32'(o_regwrite_w), 32'd0);
    chk("rst_exc",      32'(o_exc_w), 32'd0);
    chk("rst_rdata",    o_read_data_w, 32'd0);
    chk("rst_alu",      o_alu_result_w, 32'd0);
    chk("rst_pc4",      o_pc4_w, 32'd0);
    chk("rst_req",      32'(dmem_if.req), 32'd0);
    chk("rst_stall",    32'(o_stall_m), 32'd0);
    @(posedge i_clk);
    #1;
    idle_inputs();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    //     mr    mw    rw    f3     addr          wdata          rdata          dly exc    exp_read       st rq be       exp_wdata
    issue(1'b0, 1'b1, 1'b0, F3_B,  32'h0000_0103, 32'h0000_00AB, 32'h0,         0, 2'b00, 32'h0,          0, 1, 4'b1000, 32'hABAB_ABAB);
    issue(1'b1, 1'b0, 1'b1, F3_B,  32'h0000_0102, 32'h0,         32'h0080_0000, 3, 2'b00, 32'hFFFF_FF80, 3, 4, 4'b1111, 32'h0);
    issue(1'b1, 1'b0, 1'b1, F3_BU, 32'h0000_0102, 32'h0,         32'h0080_0000, 3, 2'b00, 32'h0000_0080, 3, 4, 4'b1111, 32'h0);
    issue(1'b0, 1'b1, 1'b0, F3_H,  32'h0000_0102, 32'h1234_CDEF, 32'h0,         1, 2'b00, 32'h0,          1, 2, 4'b1100, 32'hCDEF_CDEF);
    issue(1'b1, 1'b0, 1'b1, F3_H,  32'h0000_0102, 32'h0,         32'h8001_0000, 0, 2'b00, 32'hFFFF_8001, 0, 1, 4'b1111, 32'h0);
    issue(1'b1, 1'b0, 1'b1, F3_HU, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 2'b00, 32'h0000_8001, 0, 1, 4'b1111, 32'h0);
    issue(1'b0, 1'b1, 1'b0, F3_W,  32'h0000_0104, 32'h89AB_CDEF, 32'h0,         2, 2'b00, 32'h0,          2, 3, 4'b1111, 32'h89AB_CDEF);
    issue(1'b1, 1'b0, 1'b1, F3_W,  32'h0000_0100, 32'h0,         32'h1357_9BDF, 0, 2'b00, 32'h1357_9BDF, 0, 1, 4'b1111, 32'h0);
    issue(1'b1, 1'b0, 1'b1, F3_W,  32'h0000_0006, 32'h0,         32'h0,        -1, 2'b01, 32'h0,          0, 0, 4'b1111, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 3'b100,32'h0000_0100, 32'h0,         32'h0,        -1, 2'b10, 32'h0,          0, 0, 4'b1111, 32'h0);
    issue(1'b1, 1'b1, 1'b1, F3_W,  32'h0000_0100, 32'h0,         32'h0,        -1, 2'b10, 32'h0,          0, 0, 4'b1111, 32'h0);
    issue(1'b1, 1'b0, 1'b1, F3_W,  32'h0000_0108, 32'h0,         32'h0,        -1, 2'b11, 32'h0,          TO, TO+1, 4'b1111, 32'h0);
    // After the abort the FSM must be back in IDLE: a zero-wait access completes without stall
    issue(1'b1, 1'b0, 1'b1, F3_B,  32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 2'b00, 32'h0000_007F, 0, 1, 4'b1111, 32'h0);
    // Non-memory op; the ready pulse with no request must be ignored
    issue(1'b0, 1'b0, 1'b1, F3_W,  32'h0000_1234, 32'h0,         32'h0,         0, 2'b00, 32'h0,          0, 0, 4'b1111, 32'h0);

    // Spurious ready while idle
    dmem_if.ready = 1'b1;
    dmem_if.rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    chk("spur_req",   32'(dmem_if.req), 32'd0);
    chk("spur_stall", 32'(o_stall_m), 32'd0);
    @(posedge i_clk);
    #1;
    chk("spur_wb_valid", 32'(o_valid_w), 32'd0);
    idle_inputs();

    // Reset asserted in the second wait cycle of a hung load
    i_valid_m = 1'b1; i_memread_m = 1'b1; i_regwrite_m = 1'b1;
    i_funct3_m = F3_W; i_alu_result_m = 32'h10C; i_rd_addr_m = 5'd7;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    chk("wait_stall", 32'(o_stall_m), 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("rstw_req",   32'(dmem_if.req), 32'd0);
    chk("rstw_stall", 32'(o_stall_m), 32'd0);
    @(posedge i_clk);
    #1;
    chk("rstw_req_post",   32'(dmem_if.req), 32'd0);
    chk("rstw_stall_post", 32'(o_stall_m), 32'd0);
    chk("rstw_valid_w",    32'(o_valid_w), 32'd0);
    chk("rstw_regwrite",   32'(o_regwrite_w), 32'd0);
    chk("rstw_exc",        32'(o_exc_w), 32'd0);
    idle_inputs();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    // The FSM restarts in IDLE after reset
    issue(1'b1, 1'b0, 1'b1, F3_W,  32'h0000_0110, 32'h0,         32'hCAFE_F00D, 0, 2'b00, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'h0);

    repeat (2) @(posedge i_clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
